// File: rtl/ram_data_arbiter_if.sv
// Request/response bus used on both sides of the RAM data arbiter.
// Fields: req/addr/we/be/wdata (requester to memory), gnt/rvalid/rdata (memory to requester).
interface ram_data_arbiter_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_data_arbiter.sv
// Two-master round-robin arbiter onto one RAM data port, in-order response routing.
// Ports: clk, rst (sync, active-high); m0_if/m1_if (master side, slave modport);
// s_if (RAM side, master modport); err_o (sticky: response with nothing outstanding).
module ram_data_arbiter #(
    parameter int ADDR_WIDTH      = 20,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    ram_data_arbiter_if.slave   m0_if,
    ram_data_arbiter_if.slave   m1_if,
    ram_data_arbiter_if.master  s_if,
    output logic                err_o
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          err_q, err_d;
    logic          id_q [MAX_OUTSTANDING];

    logic full, empty, pop, push, can_push;
    logic sel0, sel1, head_id;

    assign full    = (cnt_q == MAX_CNT);
    assign empty   = (cnt_q == '0);
    assign head_id = id_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO may still grant.
    assign pop      = !rst && s_if.rvalid && !empty;
    assign can_push = !full || pop;

    // Round-robin: on contention pick the master not granted last.
    assign sel0 = !rst && can_push && m0_if.req && (!m1_if.req || last_q);
    assign sel1 = !rst && can_push && m1_if.req && (!m0_if.req || !last_q);
    assign push = (sel0 || sel1) && s_if.gnt;

    always_comb begin
        s_if.req   = sel0 || sel1;
        s_if.addr  = '0;
        s_if.we    = 1'b0;
        s_if.be    = '0;
        s_if.wdata = '0;
        if (sel0) begin
            s_if.addr  = m0_if.addr;
            s_if.we    = m0_if.we;
            s_if.be    = m0_if.be;
            s_if.wdata = m0_if.wdata;
        end else if (sel1) begin
            s_if.addr  = m1_if.addr;
            s_if.we    = m1_if.we;
            s_if.be    = m1_if.be;
            s_if.wdata = m1_if.wdata;
        end
    end

    assign m0_if.gnt = sel0 && s_if.gnt;
    assign m1_if.gnt = sel1 && s_if.gnt;

    assign m0_if.rvalid = pop && !head_id;
    assign m1_if.rvalid = pop && head_id;
    assign m0_if.rdata  = (pop && !head_id) ? s_if.rdata : '0;
    assign m1_if.rdata  = (pop && head_id)  ? s_if.rdata : '0;

    assign err_o = err_q && !rst;

    always_comb begin
        last_d   = last_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (push) begin
            last_d   = sel1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (s_if.rvalid && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            id_q[wr_ptr_q] <= sel1;
        end
    end
endmodule

// File: doc/ram_data_arbiter.md
RAM_DATA_ARBITER -- requirements
Module: ram_data_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, is the byte-address width of the RAM data port.
REQ-002 Parameter MAX_OUTSTANDING, default 4, is the maximum number of granted requests awaiting rvalid; it SHALL be a power of two, 2 or more.
REQ-003 clk  input  1  is the single clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  is the reset: synchronous, active-high.
REQ-005 mN_req_i  input  1  is the master N request, for N = 0 (core LSU) and N = 1 (debug/DMA).
REQ-006 mN_addr_i  input  ADDR_WIDTH  is the master N address. mN_we_i  input  1  is its write enable. mN_be_i  input  4  is its byte enable. mN_wdata_i  input  32  is its write data.
REQ-007 mN_gnt_o  output  1  is the master N grant. mN_rvalid_o  output  1  is its response valid. mN_rdata_o  output  32  is its read data.
REQ-008 s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o  outputs  1/ADDR_WIDTH/1/4/32  drive the RAM data port.
REQ-009 s_gnt_i, s_rvalid_i, s_rdata_i  inputs  1/1/32  are the RAM data port responses.

Function
REQ-010 Slave protocol: a transfer occurs in a cycle with s_req_o && s_gnt_i. Responses SHALL return in order, one s_rvalid_i per transfer, at least 1 cycle after the transfer.
REQ-011 Arbitration SHALL be combinational within the cycle. Only one master SHALL be selected, and only if the master has req high and the ID FIFO is not full.
REQ-012 If exactly one master requests, that master SHALL be selected.
REQ-013 If both masters request, the master not granted last SHALL be selected (round-robin). A pointer last_q, reset 0, SHALL update to the granted master index on every transfer.
REQ-014 The slave port SHALL be a mux of the selected master's signals. s_req_o SHALL be 0 when no master is selected, and the unselected fields SHALL then be 0.
REQ-015 mN_gnt_o SHALL equal (master N selected) && s_gnt_i. The unselected master's gnt SHALL be 0.
REQ-016 An ID FIFO of depth MAX_OUTSTANDING SHALL push the granted master index on every transfer.
REQ-017 The ID FIFO SHALL pop on every s_rvalid_i. The popped index SHALL route the response: the matching mN_rvalid_o = 1 and mN_rdata_o = s_rdata_i.
REQ-018 The non-addressed master SHALL see rvalid 0 and rdata 0.
REQ-019 A push and a pop in the same cycle SHALL leave the count unchanged and SHALL be legal when the FIFO is full. While full, the FIFO SHALL accept the push only if a pop occurs that cycle. When full with no pop, no master SHALL be selected.
REQ-020 Read and write pointers SHALL wrap modulo MAX_OUTSTANDING. The count SHALL be $clog2(MAX_OUTSTANDING)+1 bits wide and range 0..MAX_OUTSTANDING.
REQ-021 s_rvalid_i with an empty FIFO is a protocol error. It SHALL be dropped: no mN_rvalid_o, no pointer change. A sticky err_o (output, 1) SHALL be set and cleared only by reset.
REQ-022 Writes SHALL produce responses exactly like reads. Both masters SHALL receive rvalid for writes.
REQ-023 A master holding req without gnt SHALL keep address/data stable; the arbiter SHALL NOT check this.

Reset
REQ-024 While rst = 1 at posedge clk, the following SHALL be cleared: last_q = 0, FIFO count and pointers = 0, err_o = 0.
REQ-025 During reset, s_req_o and all mN_gnt_o / mN_rvalid_o SHALL be 0 regardless of inputs.
REQ-026 A reset asserted with transfers outstanding SHALL discard them. Responses arriving after reset deassertion SHALL set err_o per REQ-021.

Verification
REQ-027 Only m0 requests a read of 0x80 while s_gnt_i = 1 and the RAM returns rvalid 1 cycle later -> m0_gnt_o = 1 in cycle 0; in cycle 1, m0_rvalid_o = 1 with s_rdata_i, and m1_rvalid_o = 0.
REQ-028 Both masters request continuously for 6 cycles after reset -> grant order m1, m0, m1, m0, m1, m0, with rvalid delivered to the same sequence.
REQ-029 MAX_OUTSTANDING = 4 and the slave withholds rvalid -> 4 grants, then no grant while full.
REQ-030 Follow-on to REQ-029: assert one s_rvalid_i while m0 requests -> the pop plus a same-cycle grant keeps the count at 4.
REQ-031 s_rvalid_i pulses with the FIFO empty -> err_o = 1 next cycle, no mN_rvalid_o, and err_o stays 1 until rst.
REQ-032 rst is asserted for 1 cycle with 2 transfers outstanding -> all outputs are 0 in that cycle and the count is 0 after it.
REQ-033 m1 writes be = 4'b0011 while m0 is idle -> s_be_o = 4'b0011 and s_we_o = 1, and m1 receives rvalid.
